// File: rtl/branch_redirect_ctrl.sv
// Branch resolution and fetch-redirect sequencer: compares execute-stage outcomes
// against the front-end prediction, drives redirect/flush, predictor update and event counters.
module branch_redirect_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_i,
  input  logic             is_b_type_i,
  input  logic             is_jump_i,
  input  logic             branch_taken_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  target_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             flush_o,
  output logic             upd_valid_o,
  output logic [XLEN-1:0]  upd_pc_o,
  output logic             upd_taken_o,
  output logic [XLEN-1:0]  upd_target_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t state;

  logic            accept_p0;
  logic            is_ctrl_p0;
  logic            actual_taken_p0;
  logic            mispred_p0;
  logic [XLEN-1:0] correct_pc_p0;

  // Sequential fall-through PC; wraps at the top of the address space.
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return cnt + CNT_W'(1);
  endfunction

  // Stage p0: resolve the execute-stage instruction against its prediction
  always_comb begin
    accept_p0       = ex_valid_i & ~flush_o;
    is_ctrl_p0      = is_b_type_i | is_jump_i;
    actual_taken_p0 = is_jump_i | (is_b_type_i & branch_taken_i);
    if (is_ctrl_p0) begin
      mispred_p0 = (actual_taken_p0 != pred_taken_i) |
                   (actual_taken_p0 & pred_taken_i & (pred_target_i != target_i));
    end else begin
      mispred_p0 = pred_taken_i;
    end
    correct_pc_p0 = actual_taken_p0 ? target_i : seq_pc(pc_i);
  end

  // Stage p1: registered redirect, update strobe and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      redirect_valid_o <= 1'b0;
      flush_o          <= 1'b0;
      redirect_pc_o    <= '0;
      upd_valid_o      <= 1'b0;
      upd_pc_o         <= '0;
      upd_taken_o      <= 1'b0;
      upd_target_o     <= '0;
      branch_cnt_o     <= '0;
      mispred_cnt_o    <= '0;
    end else begin
      upd_valid_o <= accept_p0 & is_ctrl_p0;
      if (accept_p0 & is_ctrl_p0) begin
        upd_pc_o     <= pc_i;
        upd_taken_o  <= actual_taken_p0;
        upd_target_o <= target_i;
        branch_cnt_o <= cnt_inc(branch_cnt_o);
      end
      if (accept_p0 & mispred_p0) begin
        mispred_cnt_o <= cnt_inc(mispred_cnt_o);
      end

      case (state)
        IDLE: begin
          if (accept_p0 & mispred_p0) begin
            state            <= REDIRECT;
            redirect_valid_o <= 1'b1;
            flush_o          <= 1'b1;
            redirect_pc_o    <= correct_pc_p0;
          end
        end
        REDIRECT: begin
          // Target stays frozen until fetch takes it; wrong-path events are masked by flush_o.
          if (redirect_ready_i) begin
            state            <= IDLE;
            redirect_valid_o <= 1'b0;
            flush_o          <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          redirect_valid_o <= 1'b0;
          flush_o          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with hand-computed expectations (CNT_W=4 build).
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid_i;
  logic             is_b_type_i;
  logic             is_jump_i;
  logic             branch_taken_i;
  logic             pred_taken_i;
  logic [XLEN-1:0]  pred_target_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  target_i;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             redirect_ready_i;
  logic             flush_o;
  logic             upd_valid_o;
  logic [XLEN-1:0]  upd_pc_o;
  logic             upd_taken_o;
  logic [XLEN-1:0]  upd_target_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .is_b_type_i      (is_b_type_i),
    .is_jump_i        (is_jump_i),
    .branch_taken_i   (branch_taken_i),
    .pred_taken_i     (pred_taken_i),
    .pred_target_i    (pred_target_i),
    .pc_i             (pc_i),
    .target_i         (target_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .flush_o          (flush_o),
    .upd_valid_o      (upd_valid_o),
    .upd_pc_o         (upd_pc_o),
    .upd_taken_o      (upd_taken_o),
    .upd_target_o     (upd_target_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic j, input logic tk,
                       input logic pt, input logic [XLEN-1:0] ptgt,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt);
    ex_valid_i     = v;
    is_b_type_i    = b;
    is_jump_i      = j;
    branch_taken_i = tk;
    pred_taken_i   = pt;
    pred_target_i  = ptgt;
    pc_i           = pc;
    target_i       = tgt;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    redirect_ready_i = 1'b0;
    idle_in();
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_rv",    redirect_valid_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_upd",   upd_valid_o, 0);
    check("rst_bcnt",  branch_cnt_o, 0);
    check("rst_mcnt",  mispred_cnt_o, 0);

    // BEQ taken, predicted not taken; ready already high
    redirect_ready_i = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 64'h1000, 64'h1040);
    tick();
    idle_in();
    check("beq_rv",     redirect_valid_o, 1);
    check("beq_flush",  flush_o, 1);
    check("beq_rpc",    redirect_pc_o, 64'h1040);
    check("beq_upd",    upd_valid_o, 1);
    check("beq_updtk",  upd_taken_o, 1);
    check("beq_updpc",  upd_pc_o, 64'h1000);
    check("beq_bcnt",   branch_cnt_o, 1);
    check("beq_mcnt",   mispred_cnt_o, 1);
    tick();
    check("beq_idle_rv",    redirect_valid_o, 0);
    check("beq_idle_flush", flush_o, 0);
    check("beq_idle_upd",   upd_valid_o, 0);

    // BNE not taken, predicted taken; fetch stalls for 5 cycles
    redirect_ready_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h2080, 64'h2000, 64'h2080);
    tick();
    check("bne_rv",   redirect_valid_o, 1);
    check("bne_rpc",  redirect_pc_o, 64'h2004);
    check("bne_bcnt", branch_cnt_o, 2);
    check("bne_mcnt", mispred_cnt_o, 2);
    check("bne_updtgt", upd_target_o, 64'h2080);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h5000, 64'h5500);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rpc",   redirect_pc_o, 64'h2004);
      check("hold_flush", flush_o, 1);
      check("hold_rv",    redirect_valid_o, 1);
      check("hold_upd",   upd_valid_o, 0);
      check("hold_bcnt",  branch_cnt_o, 2);
      check("hold_mcnt",  mispred_cnt_o, 2);
    end
    redirect_ready_i = 1'b1;
    idle_in();
    tick();
    check("bne_release_rv", redirect_valid_o, 0);

    // JAL with wrong predicted target
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h3200, 64'h3000, 64'h3100);
    tick();
    idle_in();
    check("jal_bad_rv",   redirect_valid_o, 1);
    check("jal_bad_rpc",  redirect_pc_o, 64'h3100);
    check("jal_bad_mcnt", mispred_cnt_o, 3);
    check("jal_bad_bcnt", branch_cnt_o, 3);
    tick();
    // JAL with correct target: update only
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h3100, 64'h3000, 64'h3100);
    tick();
    idle_in();
    check("jal_ok_rv",   redirect_valid_o, 0);
    check("jal_ok_upd",  upd_valid_o, 1);
    check("jal_ok_bcnt", branch_cnt_o, 4);
    check("jal_ok_mcnt", mispred_cnt_o, 3);

    // Both class bits set: jump wins, so taken despite branch_taken_i=0
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h6100, 64'h6000, 64'h6100);
    tick();
    idle_in();
    check("prio_rv",    redirect_valid_o, 0);
    check("prio_updtk", upd_taken_o, 1);
    check("prio_bcnt",  branch_cnt_o, 5);

    // Non-branch false hit
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4800, 64'h4000, 64'h4444);
    tick();
    idle_in();
    check("nb_rv",   redirect_valid_o, 1);
    check("nb_rpc",  redirect_pc_o, 64'h4004);
    check("nb_upd",  upd_valid_o, 0);
    check("nb_bcnt", branch_cnt_o, 5);
    check("nb_mcnt", mispred_cnt_o, 4);
    tick();
    check("nb_idle_rv", redirect_valid_o, 0);

    // Asynchronous reset while a redirect is pending
    redirect_ready_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 64'h7000, 64'h7040);
    tick();
    idle_in();
    check("prerst_rv", redirect_valid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rv",    redirect_valid_o, 0);
    check("arst_flush", flush_o, 0);
    check("arst_rpc",   redirect_pc_o, 0);
    check("arst_upd",   upd_valid_o, 0);
    check("arst_bcnt",  branch_cnt_o, 0);
    check("arst_mcnt",  mispred_cnt_o, 0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_rv", redirect_valid_o, 0);

    // Counter wrap: 15 correct not-taken predictions then one more
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 64'h8000, 64'h8100);
    for (int i = 0; i < 15; i++) tick();
    check("wrap_pre_bcnt", branch_cnt_o, 15);
    check("wrap_pre_rv",   redirect_valid_o, 0);
    tick();
    check("wrap_bcnt", branch_cnt_o, 0);
    check("wrap_mcnt", mispred_cnt_o, 0);

    // Fall-through PC wraps past the top of the address space
    redirect_ready_i = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40);
    tick();
    idle_in();
    check("pcwrap_rv",   redirect_valid_o, 1);
    check("pcwrap_rpc",  redirect_pc_o, 64'h0);
    check("pcwrap_mcnt", mispred_cnt_o, 1);
    check("pcwrap_bcnt", branch_cnt_o, 1);
    tick();
    check("pcwrap_idle_rv", redirect_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the fetch-redirect and pipeline-flush that follow every control-flow instruction resolved in execute. Compares the execute-stage branch outcome against the front-end prediction, holds a redirect request to fetch under a valid/ready handshake, squashes wrong-path execute results until fetch accepts, and emits predictor-update and performance-count information. Sits between the execute stage (branch comparator output) and the fetch unit.

Parameters:
XLEN, 64, width of PC and target values
CNT_W, 32, width of the branch and mispredict event counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
ex_valid_i  input  1  execute stage holds a valid instruction this cycle
is_b_type_i  input  1  instruction is a conditional branch
is_jump_i  input  1  instruction is JAL/JALR
branch_taken_i  input  1  resolved condition from the branch comparator (meaningful only when is_b_type_i)
pred_taken_i  input  1  front end predicted taken for this instruction
pred_target_i  input  XLEN  front-end predicted target
pc_i  input  XLEN  PC of the execute-stage instruction
target_i  input  XLEN  computed branch/jump target
redirect_valid_o  output  1  redirect request to fetch
redirect_pc_o  output  XLEN  correct next PC; stable while redirect_valid_o=1
redirect_ready_i  input  1  fetch accepts redirect this cycle
flush_o  output  1  squash decode/execute contents; execute events ignored while high
upd_valid_o  output  1  one-cycle predictor update strobe
upd_pc_o  output  XLEN  PC of resolved control instruction
upd_taken_o  output  1  actual direction
upd_target_o  output  XLEN  actual target
branch_cnt_o  output  CNT_W  resolved control instructions (b-type or jump)
mispred_cnt_o  output  CNT_W  mispredictions detected

Behaviour:
- Reset (async, any cycle, including mid-redirect): state IDLE; all outputs 0; counters 0; pending redirect discarded.
- Event accepted only when ex_valid_i=1 and flush_o=0 (registered). Otherwise inputs ignored entirely (no update, no count).
- Resolution of an accepted event:
  - actual_taken = is_jump_i ? 1 : (is_b_type_i & branch_taken_i).
  - b-type or jump: mispredict if actual_taken != pred_taken_i, or both taken and pred_target_i != target_i.
  - neither: mispredict iff pred_taken_i=1 (false hit); no update, not counted in branch_cnt_o.
  - correct PC = actual_taken ? target_i : pc_i + 4 (modulo 2^XLEN).
  - If both is_b_type_i and is_jump_i are set, is_jump_i takes priority.
- Update: one cycle after an accepted b-type/jump event, upd_valid_o=1 for exactly one cycle with registered pc/actual_taken/target (upd_target_o = target_i regardless of direction). branch_cnt_o increments in that same cycle; mispred_cnt_o increments when a mispredict is detected (any class). Counters wrap modulo 2^CNT_W.
- FSM:
  - IDLE: flush_o=0, redirect_valid_o=0. Accepted mispredict -> REDIRECT at the next edge, loading redirect_pc_o.
  - REDIRECT: redirect_valid_o=1, flush_o=1, redirect_pc_o held constant. The state is held while redirect_ready_i=0. When redirect_ready_i=1 -> IDLE at the next edge, and redirect_valid_o/flush_o drop in that next cycle.
- Latency: mispredict in cycle N -> redirect_valid_o and flush_o high in cycle N+1. Ready in cycle N+1 -> IDLE in N+2; execute events first accepted in N+2.
- No overlap possible: events during REDIRECT are wrong-path and dropped, so at most one redirect is ever outstanding.
- Correctly predicted events: no FSM change, update/count only.

Test Plan:
- Reset mid-REDIRECT (redirect_valid_o=1, ready=0), assert rst -> all outputs 0 immediately; counters 0; after release an idle cycle shows redirect_valid_o=0.
- BEQ at pc=0x1000, target=0x1040, branch_taken_i=1, pred_taken_i=0 -> next cycle redirect_valid_o=1, flush_o=1, redirect_pc_o=0x1040, upd_valid_o=1, upd_taken_o=1, branch_cnt_o=1, mispred_cnt_o=1; ready asserted same cycle -> IDLE following cycle.
- BNE at pc=0x2000, not taken, predicted taken to 0x2080 -> redirect_pc_o=0x2004. Hold ready=0 for 5 cycles while driving ex_valid_i=1 mispredicting jumps -> redirect_pc_o stays 0x2004, counters unchanged, flush_o=1 throughout.
- JAL pc=0x3000 target=0x3100, pred_taken_i=1, pred_target_i=0x3200 -> redirect to 0x3100, mispred_cnt_o +1. Same with pred_target_i=0x3100 -> no redirect, upd_valid_o=1, branch_cnt_o +1 only.
- Non-branch at pc=0x4000 with pred_taken_i=1 -> redirect_pc_o=0x4004, upd_valid_o=0, branch_cnt_o unchanged, mispred_cnt_o +1.
- Preload branch_cnt_o to 2^CNT_W-1 via 2^CNT_W-1 correct predictions (CNT_W=4 build), one more -> wraps to 0; pc=0xFFFF_FFFF_FFFF_FFFC not-taken mispredict -> redirect_pc_o=0.
